// File: rtl/fx_ctrl_bank.sv
// fx_ctrl_bank: pedal mode FSM plus per-effect level bank with inc/dec
// editing; preset save/load is built only when FX_PRESET_EN is defined.
// Ports:
//   i_AUD_BCLK, i_rst_n (async low) - clock and reset
//   i_i2c_done - codec ready
//   i_key_* - debounced key levels
//   i_sw_sel, i_sw_en, i_preset - board switches
//   o_params - packed effect levels
//   o_fx_en - registered enables
//   o_state, o_busy, o_loop_rec, o_loop_play - FSM status
//   o_ledg, o_ledr, o_disp_val - indicators
module fx_ctrl_bank #(
  parameter int NUM_FX      = 8,
  parameter int PARAM_W     = 3,
  parameter int SEL_W       = $clog2(NUM_FX),
  parameter int NUM_PRESETS = 4,
  parameter int WRAP        = 1,
  parameter logic [NUM_FX*PARAM_W-1:0] RST_VEC = 24'h004802
) (
  input  logic                          i_AUD_BCLK,
  input  logic                          i_rst_n,
  input  logic                          i_i2c_done,
  input  logic                          i_key_inc,
  input  logic                          i_key_dec,
  input  logic                          i_key_loop,
  input  logic                          i_key_mode,
  input  logic                          i_key_preset,
  input  logic [SEL_W-1:0]              i_sw_sel,
  input  logic [NUM_FX-1:0]             i_sw_en,
  input  logic [$clog2(NUM_PRESETS)-1:0] i_preset,
  output logic [NUM_FX*PARAM_W-1:0]     o_params,
  output logic [NUM_FX-1:0]             o_fx_en,
  output logic [2:0]                    o_state,
  output logic                          o_busy,
  output logic                          o_loop_rec,
  output logic                          o_loop_play,
  output logic [8:0]                    o_ledg,
  output logic [NUM_FX-1:0]             o_ledr,
  output logic [PARAM_W-1:0]            o_disp_val
);

  localparam int PW = $clog2(NUM_PRESETS);
  localparam int CW = $clog2(NUM_FX + 1);
  localparam int FW = NUM_FX * PARAM_W;

  localparam logic [2:0] S_I2C       = 3'd0;
  localparam logic [2:0] S_PLAY      = 3'd1;
  localparam logic [2:0] S_SET       = 3'd2;
  localparam logic [2:0] S_RECD_LOOP = 3'd3;
  localparam logic [2:0] S_PLAY_LOOP = 3'd4;
  localparam logic [2:0] S_SAVE      = 3'd5;
  localparam logic [2:0] S_LOAD      = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [FW-1:0]     params_q, params_d, ed_vec;
  logic [NUM_FX-1:0] fx_en_q;
  logic inc_q, dec_q, loop_q, mode_q;
  logic inc_e, dec_e, loop_e, mode_e;

  logic [PARAM_W-1:0] sel_cur, sel_nxt;
  logic [NUM_FX-1:0]  sel_oh;

  assign inc_e  = i_key_inc  & ~inc_q;
  assign dec_e  = i_key_dec  & ~dec_q;
  assign loop_e = i_key_loop & ~loop_q;
  assign mode_e = i_key_mode & ~mode_q;

`ifdef FX_PRESET_EN
  logic                 pre_q, pre_e;
  logic [CW-1:0]        idx_q, idx_d;
  logic [PW-1:0]        slot_q, slot_d;
  logic [NUM_PRESETS-1:0] valid_q, valid_d;
  logic [PARAM_W-1:0]   mem [NUM_PRESETS*(2**SEL_W)];
  logic [PARAM_W-1:0]   rd_q, sv_data;
  logic [PW+SEL_W-1:0]  addr;
  logic [FW-1:0]        ld_vec;

  assign pre_e = i_key_preset & ~pre_q;
  assign addr  = {slot_q, idx_q[SEL_W-1:0]};

  // Word-serial transfer; load writes field idx-1 from the
  // word read on the previous cycle.
  always_comb begin
    sv_data = '0;
    ld_vec  = params_q;
    for (int i = 0; i < NUM_FX; i++) begin
      if (idx_q == CW'(i))
        sv_data = params_q[i*PARAM_W +: PARAM_W];
      if (idx_q == CW'(i + 1))
        ld_vec[i*PARAM_W +: PARAM_W] = rd_q;
    end
  end

  always_ff @(posedge i_AUD_BCLK) begin
    if (state_q == S_SAVE)
      mem[addr] <= sv_data;
    rd_q <= mem[addr];
  end
`else
  logic unused_preset;
  assign unused_preset = ^{i_key_preset, i_preset};
`endif

  always_comb begin
    sel_cur = '0;
    sel_oh  = '0;
    for (int i = 0; i < NUM_FX; i++) begin
      if (i_sw_sel == SEL_W'(i)) begin
        sel_cur   = params_q[i*PARAM_W +: PARAM_W];
        sel_oh[i] = 1'b1;
      end
    end
    sel_nxt = sel_cur;
    if (inc_e && !dec_e) begin
      if (WRAP != 0 || sel_cur != '1)
        sel_nxt = sel_cur + 1'b1;
    end else if (dec_e && !inc_e) begin
      if (WRAP != 0 || sel_cur != '0)
        sel_nxt = sel_cur - 1'b1;
    end
    ed_vec = params_q;
    for (int i = 0; i < NUM_FX; i++)
      if (sel_oh[i])
        ed_vec[i*PARAM_W +: PARAM_W] = sel_nxt;
  end

  always_comb begin
    state_d  = state_q;
    params_d = params_q;
`ifdef FX_PRESET_EN
    idx_d    = idx_q;
    slot_d   = slot_q;
    valid_d  = valid_q;
`endif
    case (state_q)
      S_I2C:
        if (i_i2c_done) state_d = S_PLAY;
      S_PLAY: begin
        if (mode_e) state_d = S_SET;
        else if (loop_e) state_d = S_RECD_LOOP;
`ifdef FX_PRESET_EN
        else if (pre_e && valid_q[i_preset]) begin
          state_d = S_LOAD;
          slot_d  = i_preset;
          idx_d   = '0;
        end
`endif
      end
      S_SET: begin
        if (mode_e) state_d = S_PLAY;
`ifdef FX_PRESET_EN
        else if (pre_e) begin
          state_d = S_SAVE;
          slot_d  = i_preset;
          idx_d   = '0;
        end
`endif
        // a loop edge outranks editing even though SET ignores it
        else if (!loop_e) params_d = ed_vec;
      end
      S_RECD_LOOP:
        if (loop_e) state_d = S_PLAY_LOOP;
      S_PLAY_LOOP:
        if (loop_e) state_d = S_PLAY;
`ifdef FX_PRESET_EN
      S_SAVE: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == CW'(NUM_FX - 1)) begin
          state_d         = S_SET;
          valid_d[slot_q] = 1'b1;
        end
      end
      S_LOAD: begin
        idx_d    = idx_q + 1'b1;
        params_d = ld_vec;
        if (idx_q == CW'(NUM_FX))
          state_d = S_PLAY;
      end
`endif
      default: state_d = S_I2C;
    endcase
  end

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_I2C;
      params_q <= RST_VEC;
      fx_en_q  <= '0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      loop_q   <= 1'b0;
      mode_q   <= 1'b0;
`ifdef FX_PRESET_EN
      pre_q    <= 1'b0;
      idx_q    <= '0;
      slot_q   <= '0;
      valid_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      params_q <= params_d;
      fx_en_q  <= i_sw_en;
      inc_q    <= i_key_inc;
      dec_q    <= i_key_dec;
      loop_q   <= i_key_loop;
      mode_q   <= i_key_mode;
`ifdef FX_PRESET_EN
      pre_q    <= i_key_preset;
      idx_q    <= idx_d;
      slot_q   <= slot_d;
      valid_q  <= valid_d;
`endif
    end
  end

  always_comb begin
    case (state_q)
      S_I2C:       o_ledg = 9'h100;
      S_PLAY:      o_ledg = 9'h001;
      S_SET:       o_ledg = 9'h002;
      S_RECD_LOOP: o_ledg = 9'h004;
      S_PLAY_LOOP: o_ledg = 9'h008;
      S_SAVE:      o_ledg = 9'h010;
      S_LOAD:      o_ledg = 9'h020;
      default:     o_ledg = 9'h000;
    endcase
  end

  assign o_params    = params_q;
  assign o_fx_en     = fx_en_q;
  assign o_state     = state_q;
  assign o_loop_rec  = (state_q == S_RECD_LOOP);
  assign o_loop_play = (state_q == S_PLAY_LOOP);
  assign o_ledr      = (state_q == S_SET) ? sel_oh : fx_en_q;
  assign o_disp_val  = (state_q == S_SET) ? sel_cur : '0;
`ifdef FX_PRESET_EN
  assign o_busy = (state_q == S_SAVE) || (state_q == S_LOAD);
`else
  assign o_busy = 1'b0;
`endif

endmodule
